// File: rtl/bus_dma_pkg.sv
// Shared definitions for the bus DMA peripheral: register indices,
// CTRL bit positions and the transfer state encoding.
package bus_dma_pkg;

    // Register indices on the register-side port
    localparam logic [2:0] REG_SRC  = 3'd0;
    localparam logic [2:0] REG_DST  = 3'd1;
    localparam logic [2:0] REG_CNT  = 3'd2;
    localparam logic [2:0] REG_CTRL = 3'd3;
    localparam logic [2:0] REG_DCLR = 3'd4;

    // CTRL write bits
    localparam int CTRL_START = 0;
    localparam int CTRL_IE    = 1;
    localparam int CTRL_ABORT = 3;

    // CTRL read bits (IE reads back at the same position it is written)
    localparam int CTRL_BUSY  = 0;
    localparam int CTRL_DONE  = 2;

    // Transfer state machine
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } dma_state_e;

endpackage

// File: rtl/bus_dma.sv
// Single-channel memory-to-memory DMA. Copies CNT words from SRC to DST
// (ascending word addresses), one read cycle then one write cycle per word.
//
// Initiator handshake: m_req is held high for the whole transfer (states RD
// and WR). A bus cycle completes only at an edge where m_gnt is high; with
// m_gnt low the FSM holds its state, no address or count advances and
// m_wen stays low. m_din is sampled at the edge of a granted RD cycle;
// m_wen follows m_gnt in WR and the slave commits the write at that edge.
module bus_dma
    import bus_dma_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cs,
    input  logic             wen,
    input  logic [2:0]       addr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             m_req,
    input  logic             m_gnt,
    output logic [WIDTH-1:0] m_aout,
    output logic [WIDTH-1:0] m_dout,
    input  logic [WIDTH-1:0] m_din,
    output logic             m_wen,
    output logic             irq
);

    dma_state_e       state_q, state_d;
    logic [WIDTH-1:0] src_q, src_d;
    logic [WIDTH-1:0] dst_q, dst_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] buf_q, buf_d;
    logic             ie_q, ie_d;
    logic             done_q, done_d;
    logic             irq_q, irq_d;

    logic busy;
    logic reg_wr;
    logic ctrl_wr;
    logic start;
    logic abort;

    // Decode register-side strobes; START only counts when idle, ABORT only when busy.
    always_comb begin
        busy    = (state_q != ST_IDLE);
        reg_wr  = cs && wen;
        ctrl_wr = reg_wr && (addr == REG_CTRL);
        start   = ctrl_wr && din[CTRL_START] && !busy;
        abort   = ctrl_wr && din[CTRL_ABORT] && busy;
    end

    // Next-state for the register file and the transfer FSM.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        ie_d    = ie_q;
        done_d  = done_q;
        irq_d   = done_q && ie_q;

        // Address/count registers are frozen while a transfer runs
        if (reg_wr && !busy) begin
            case (addr)
                REG_SRC: src_d = din;
                REG_DST: dst_d = din;
                REG_CNT: cnt_d = din;
                default: ;
            endcase
        end
        if (ctrl_wr) begin
            ie_d = din[CTRL_IE];
        end
        // DONE clear comes first so a same-cycle completion below overrides it
        if (reg_wr && (addr == REG_DCLR)) begin
            done_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (cnt_q == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (m_gnt) begin
                    buf_d   = m_din;
                    src_d   = src_q + 1'b1;
                    state_d = ST_WR;
                end
            end
            ST_WR: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (m_gnt) begin
                    dst_d = dst_q + 1'b1;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_d == '0) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            buf_q   <= '0;
            ie_q    <= 1'b0;
            done_q  <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            ie_q    <= ie_d;
            done_q  <= done_d;
            irq_q   <= irq_d;
        end
    end

    // Initiator outputs; the write strobe is suppressed on abort and reset cycles.
    always_comb begin
        m_aout = '0;
        m_dout = '0;
        m_wen  = 1'b0;
        case (state_q)
            ST_RD: m_aout = src_q;
            ST_WR: begin
                m_aout = dst_q;
                m_dout = buf_q;
                m_wen  = m_gnt && !abort && !reset;
            end
            default: ;
        endcase
    end

    // Register read mux, combinational from addr.
    always_comb begin
        dout = '0;
        case (addr)
            REG_SRC:  dout = src_q;
            REG_DST:  dout = dst_q;
            REG_CNT:  dout = cnt_q;
            REG_CTRL: begin
                dout[CTRL_BUSY] = busy;
                dout[CTRL_IE]   = ie_q;
                dout[CTRL_DONE] = done_q;
            end
            default:  dout = '0;
        endcase
    end

    assign m_req = busy;
    assign irq   = irq_q;

endmodule

// File: doc/bus_dma.md
BUS_DMA -- requirements
Module: bus_dma

Interface
REQ-001 Parameter WIDTH, default 32: bus data and address width in bits.
REQ-002 clk  input  1: single system clock; all state updates on its rising edge.
REQ-003 reset  input  1: synchronous, active-high reset.
REQ-004 cs  input  1: register-side chip select from the address decoder.
REQ-005 wen  input  1: register-side write enable, qualified by cs.
REQ-006 addr  input  3: register index.
REQ-007 din  input  WIDTH: register write data.
REQ-008 dout  output  WIDTH: register read data, combinational from addr.
REQ-009 m_req  output  1: bus ownership request to the arbiter.
REQ-010 m_gnt  input  1: bus grant from the arbiter; valid in the same cycle.
REQ-011 m_aout  output  WIDTH: initiator word address.
REQ-012 m_dout  output  WIDTH: initiator write data.
REQ-013 m_din  input  WIDTH: initiator read data, valid in the same cycle m_aout is presented.
REQ-014 m_wen  output  1: initiator write strobe; the slave commits the write at the clock edge.
REQ-015 irq  output  1: registered level interrupt.

Function
REQ-016 Register map: 0 SRC, 1 DST and 2 CNT (all R/W), 3 CTRL.
REQ-017 CTRL write bits: bit0 START, bit1 IE, bit3 ABORT.
REQ-018 CTRL read bits: bit0 BUSY, bit1 IE, bit2 DONE.
REQ-019 Register index 4: a write clears DONE; a read returns 0. Indices 5-7 read 0 and ignore writes.
REQ-020 SRC, DST and CNT are word addresses and counts; the block moves CNT words from SRC to DST with ascending addresses.
REQ-021 States: IDLE, RD, WR.
REQ-022 In RD and WR, m_req=1. In IDLE, m_req=0 and m_wen=0.
REQ-023 IDLE transitions on a START write: if CNT=0, set DONE and stay IDLE with no bus cycle; if CNT!=0, go to RD at the next edge.
REQ-024 RD: m_aout=SRC and m_wen=0. If m_gnt=1, latch m_din into the buffer, increment SRC and go to WR. If m_gnt=0, hold RD with no state change.
REQ-025 WR: m_aout=DST, m_dout=buffer and m_wen=m_gnt. If m_gnt=1, increment DST and decrement CNT. Then go to RD if the new CNT!=0; otherwise go to IDLE and set DONE.
REQ-026 Timing with m_gnt held high: the START write lands at edge N; word k is read in cycle N+1+2k and written in cycle N+2+2k.
REQ-027 Throughput is 2 granted cycles per word.
REQ-028 SRC and DST increment modulo 2^WIDTH (0xFFFFFFFF wraps to 0).
REQ-029 While BUSY, writes to SRC, DST, CNT and START are ignored. IE writes and the DONE clear still take effect.
REQ-030 ABORT while BUSY goes to IDLE at the next edge. No m_wen is issued in the abort cycle, DONE is not set, and SRC, DST and CNT keep their progress values.
REQ-031 When the DONE clear and the completion of the final write occur in the same cycle, the set wins.
REQ-032 m_aout=0 and m_dout=0 whenever the state is IDLE.
REQ-033 irq is registered from DONE&IE, so it follows DONE&IE one cycle later.

Reset
REQ-034 reset=1 at a clock edge gives state IDLE; SRC, DST, CNT and the buffer =0; IE=0 and DONE=0; irq=0, m_req=0 and m_wen=0.
REQ-035 Reset overrides any register write in the same cycle.
REQ-036 Reset aborts an in-flight transfer, and no write is committed in that cycle.

Structure
REQ-037 The register indices, CTRL bit positions and state encoding are defined in the shared peripheral package.
REQ-038 No sub-module is required; the FSM and the register file stay in one module.
REQ-039 In the SoC, bus_dma sits behind an arbiter that muxes the CPU and DMA onto the bus.

Verification
REQ-040 SRC=0x100, DST=0x200, CNT=4, START with m_gnt=1: memory 0x200-0x203 equals 0x100-0x103; BUSY is high for 8 cycles; DONE=1; SRC=0x104, DST=0x204, CNT=0.
REQ-041 CNT=0 then START: no m_req pulse; DONE=1 in the next cycle; with IE=1, irq=1 one cycle later.
REQ-042 m_gnt toggles 1,0,0,1,... during a 3-word copy: no address advances and no m_wen while m_gnt=0; the final memory content is correct.
REQ-043 SRC=0xFFFFFFFF, CNT=2: the second read is from address 0; the second write goes to DST+1.
REQ-044 ABORT issued in a WR cycle of word 2 of 5: state returns to IDLE; only words 0-1 are written; CNT=3 and DONE=0.
REQ-045 Reset asserted mid-transfer, with a CNT write attempted while BUSY beforehand: that write is ignored; after reset all registers are 0 and m_wen=0.
